sonar_line_buffer_ctrl: RTL and testbench
=========================================

SONAR_LINE_BUFFER_CTRL -- requirements
Module: sonar_line_buffer_ctrl

Interface
REQ-001 SHALL have parameter LINE_LEN, default 1024, meaning the number of samples per full line (legal range 1..1024).
REQ-002 SHALL have port clk, input, 1 bit: the single clock for all logic and for both RAM ports.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port wr_valid, input, 1 bit: an echo sample is offered.
REQ-005 SHALL have port wr_data, input, 8 bits: the echo sample.
REQ-006 SHALL have port wr_last, input, 1 bit: qualified by wr_valid; closes the line early (short line).
REQ-007 SHALL have port wr_ready, output, 1 bit: the write bank can accept a sample.
REQ-008 SHALL have port rd_valid, output, 1 bit: rd_data holds a valid sample.
REQ-009 SHALL have port rd_data, output, 8 bits: the streamed sample.
REQ-010 SHALL have port rd_last, output, 1 bit: marks the final sample of the line.
REQ-011 SHALL have port rd_ready, input, 1 bit: the consumer accepts the sample.
REQ-012 SHALL have port ram_ada, output, 11 bits, plus ram_din, output, 8 bits, and ram_cea, output, 1 bit: the RAM write port.
REQ-013 SHALL have port ram_adb, output, 11 bits, plus ram_ceb, output, 1 bit: the RAM read port; ram_dout, input, 8 bits, is valid exactly 1 cycle after a ram_ceb cycle.
REQ-014 SHALL have port overrun_cnt, output, 8 bits: a saturating count of samples dropped.

Function
REQ-015 SHALL split the 2048x8 RAM into two banks, bank b = address bit 10; sample i of a line maps to address {b, i[9:0]}.
REQ-016 SHALL keep, per bank, a full flag and an 11-bit stored length (1..1024).
REQ-017 Write side: wr_ready = !full[wbank]; a transfer occurs when wr_valid && wr_ready; on a transfer, ram_cea=1, ram_ada={wbank,wcnt}, ram_din=wr_data in the same cycle.
REQ-018 The line SHALL close when wcnt==LINE_LEN-1 or wr_last on a transfer; on close: full[wbank]<=1, len[wbank]<=wcnt+1, wcnt<=0, wbank<=~wbank.
REQ-019 wr_valid && !wr_ready SHALL increment overrun_cnt, saturating at 255; the sample is discarded.
REQ-020 Read FSM states SHALL be R_IDLE, R_STREAM and R_DRAIN.
REQ-021 R_IDLE -> R_STREAM when full[rbank]; rcnt<=0.
REQ-022 In R_STREAM, a RAM read SHALL issue (ram_ceb=1, ram_adb={rbank,rcnt}) only when output-FIFO occupancy plus in-flight reads < 2; on issue rcnt++; after issuing index len[rbank]-1 -> R_DRAIN.
REQ-023 R_DRAIN -> R_IDLE when the last sample is accepted (rd_valid && rd_ready && rd_last); same cycle: full[rbank]<=0, rbank<=~rbank.
REQ-024 ram_dout SHALL be captured into a 2-entry output FIFO; rd_valid = FIFO not empty; rd_data and rd_last come from the head entry; no sample SHALL be lost or duplicated under any rd_ready pattern.
REQ-025 rd_data/rd_valid/rd_last SHALL stay stable while rd_valid && !rd_ready.
REQ-026 When the read side frees a bank in the same cycle that the write side is stalled on it, wr_ready SHALL rise the next cycle; a write close and a read free on different banks in the same cycle SHALL both take effect.
REQ-027 Sustained throughput SHALL be 1 sample/cycle on both sides when unstalled.
REQ-028 Lines SHALL be read out in write order; a line is never readable before its close.

Reset
REQ-029 On resetn low, asynchronously: wbank=0, rbank=0, wcnt=0, rcnt=0, full=00, len=0, FIFO empty, in-flight cleared, FSM=R_IDLE, overrun_cnt=0.
REQ-030 During reset, all outputs SHALL be 0 except wr_ready, which SHALL be 1.
REQ-031 Reset asserted mid-line or mid-stream SHALL discard the partial line and any unread data; no RAM write follows deassertion until a new transfer occurs.

Verification
REQ-032 With LINE_LEN=4, write 0x10..0x13 with rd_ready=1 -> RAM writes at addresses 0..3; rd_valid stream 0x10,0x11,0x12,0x13 with rd_last on 0x13; full returns to 00.
REQ-033 Write 3 samples with wr_last on the 3rd, then 4 samples -> first line reads out 3 samples from bank 0, second line reads 4 samples from addresses 0x400..0x403.
REQ-034 With rd_ready=0, fill both banks, then offer 5 more samples -> wr_ready=0 and overrun_cnt=5; raise rd_ready -> wr_ready rises 1 cycle after bank 0's rd_last is accepted.
REQ-035 Apply a random rd_ready toggle over 1000 lines with LINE_LEN=1024 -> the output sequence matches the input exactly, and rd_data is held stable while stalled.
REQ-036 Assert resetn low after 2 samples of a line and during a stream -> all outputs reach their reset values immediately; the next line begins at address 0.
REQ-037 Offer 300 samples while stalled -> overrun_cnt saturates at 255.

Source files
------------

// File: rtl/sonar_line_buffer_ctrl.sv
// Sonar line buffer controller.
// Ping-pongs echo lines between two 1024-sample banks of an external 2048x8 RAM.
// Bank 0 is the lower half of the RAM and bank 1 is the upper half.
// Full lines are streamed out in write order through a 2-entry output FIFO.
module sonar_line_buffer_ctrl #(
  parameter int LINE_LEN = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        rd_last,
  input  logic        rd_ready,
  output logic [10:0] ram_ada,
  output logic [7:0]  ram_din,
  output logic        ram_cea,
  output logic [10:0] ram_adb,
  output logic        ram_ceb,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  overrun_cnt
);

  localparam logic [9:0] LAST_IDX = 10'(LINE_LEN - 1);

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_STREAM = 2'd1;
  localparam logic [1:0] R_DRAIN  = 2'd2;

  // bank bookkeeping
  logic        wbank_r;
  logic        rbank_r;
  logic [9:0]  wcnt_r;
  logic [9:0]  rcnt_r;
  logic [1:0]  full_r;
  logic [10:0] len_r [2];
  logic [1:0]  state_r;
  logic [7:0]  overrun_r;

  // read pipeline: one RAM read in flight plus the 2-entry output FIFO
  logic        pend_r;
  logic        pend_last_r;
  logic [7:0]  fifo_data_r [2];
  logic        fifo_last_r [2];
  logic        fifo_wptr_r;
  logic        fifo_rptr_r;
  logic [1:0]  fifo_cnt_r;

  logic        wr_ready_s;
  logic        wr_xfer_s;
  logic        wr_close_s;
  logic        rd_valid_s;
  logic        pop_s;
  logic [10:0] cur_len_s;
  logic        issue_last_s;
  logic [2:0]  occ_s;
  logic        issue_s;
  logic        free_s;

  assign wr_ready_s   = !full_r[wbank_r];
  // wr_valid is masked by resetn so that every RAM strobe stays low during reset
  assign wr_xfer_s    = resetn && wr_valid && wr_ready_s;
  assign wr_close_s   = wr_xfer_s && ((wcnt_r == LAST_IDX) || wr_last);

  assign rd_valid_s   = (fifo_cnt_r != 2'd0);
  assign pop_s        = rd_valid_s && rd_ready;
  assign cur_len_s    = len_r[rbank_r];
  assign issue_last_s = ({1'b0, rcnt_r} == (cur_len_s - 11'd1));
  // Room is the occupancy after this cycle's pop, so a head that is being
  // accepted frees its slot at once and the stream keeps 1 sample/cycle.
  assign occ_s        = {1'b0, fifo_cnt_r} + {2'b00, pend_r} - {2'b00, pop_s};
  assign issue_s      = (state_r == R_STREAM) && (occ_s < 3'd2);
  assign free_s       = (state_r == R_DRAIN) && pop_s && fifo_last_r[fifo_rptr_r];

  assign wr_ready     = wr_ready_s;
  assign ram_cea      = wr_xfer_s;
  assign ram_ada      = wr_xfer_s ? {wbank_r, wcnt_r} : 11'd0;
  assign ram_din      = wr_xfer_s ? wr_data : 8'd0;
  assign ram_ceb      = issue_s;
  assign ram_adb      = issue_s ? {rbank_r, rcnt_r} : 11'd0;
  assign rd_valid     = rd_valid_s;
  assign rd_data      = fifo_data_r[fifo_rptr_r];
  assign rd_last      = rd_valid_s && fifo_last_r[fifo_rptr_r];
  assign overrun_cnt  = overrun_r;

  // Write side: advance the sample index and flip to the other bank on close.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wcnt_r  <= 10'd0;
      wbank_r <= 1'b0;
    end else if (wr_close_s) begin
      wcnt_r  <= 10'd0;
      wbank_r <= ~wbank_r;
    end else if (wr_xfer_s) begin
      wcnt_r  <= wcnt_r + 10'd1;
    end
  end

  // Bank status: the writer marks a bank full on close and the reader frees it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full_r <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        len_r[b] <= 11'd0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_close_s && (wbank_r == 1'(b))) begin
          full_r[b] <= 1'b1;
          len_r[b]  <= {1'b0, wcnt_r} + 11'd1;
        end else if (free_s && (rbank_r == 1'(b))) begin
          full_r[b] <= 1'b0;
        end
      end
    end
  end

  // Count samples offered while the write bank is still full (saturating).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun_r <= 8'd0;
    end else if (wr_valid && !wr_ready_s && (overrun_r != 8'hFF)) begin
      overrun_r <= overrun_r + 8'd1;
    end
  end

  // Read FSM: wait for a full bank, issue its reads, then drain until rd_last is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= R_IDLE;
      rcnt_r  <= 10'd0;
      rbank_r <= 1'b0;
    end else begin
      case (state_r)
        R_IDLE: begin
          if (full_r[rbank_r]) begin
            state_r <= R_STREAM;
            rcnt_r  <= 10'd0;
          end
        end
        R_STREAM: begin
          if (issue_s) begin
            rcnt_r <= rcnt_r + 10'd1;
            if (issue_last_s) begin
              state_r <= R_DRAIN;
            end
          end
        end
        R_DRAIN: begin
          if (free_s) begin
            state_r <= R_IDLE;
            rbank_r <= ~rbank_r;
          end
        end
        default: begin
          state_r <= R_IDLE;
        end
      endcase
    end
  end

  // Track the single RAM read in flight and whether it carries the line's last sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_r      <= 1'b0;
      pend_last_r <= 1'b0;
    end else begin
      pend_r      <= issue_s;
      pend_last_r <= issue_s && issue_last_s;
    end
  end

  // Output FIFO: capture ram_dout one cycle after its read, pop on rd_valid && rd_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo_wptr_r <= 1'b0;
      fifo_rptr_r <= 1'b0;
      fifo_cnt_r  <= 2'd0;
      for (int e = 0; e < 2; e++) begin
        fifo_data_r[e] <= 8'd0;
        fifo_last_r[e] <= 1'b0;
      end
    end else begin
      if (pend_r) begin
        fifo_data_r[fifo_wptr_r] <= ram_dout;
        fifo_last_r[fifo_wptr_r] <= pend_last_r;
        fifo_wptr_r              <= ~fifo_wptr_r;
      end
      if (pop_s) begin
        fifo_rptr_r <= ~fifo_rptr_r;
      end
      case ({pend_r, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_line_buffer_ctrl.sv
// Directed bench for sonar_line_buffer_ctrl with LINE_LEN=4, a behavioural
// 2048x8 RAM, and a monitor that logs RAM addresses and the output stream.
module tb_sonar_line_buffer_ctrl;

  localparam int LL = 4;

  logic        clk;
  logic        resetn;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_last;
  logic        wr_ready;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_last;
  logic        rd_ready;
  logic [10:0] ram_ada;
  logic [7:0]  ram_din;
  logic        ram_cea;
  logic [10:0] ram_adb;
  logic        ram_ceb;
  logic [7:0]  ram_dout;
  logic [7:0]  overrun_cnt;

  int errors = 0;
  int checks = 0;

  logic [8:0]  rx_q  [$];
  logic [8:0]  exp_q [$];
  logic [10:0] wa_q  [$];
  logic [10:0] ra_q  [$];
  bit          track_exp = 1'b0;
  int          wpos = 0;

  logic [7:0]  ram_mem [2048];

  sonar_line_buffer_ctrl #(.LINE_LEN(LL)) dut (
    .clk(clk), .resetn(resetn),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
    .ram_ada(ram_ada), .ram_din(ram_din), .ram_cea(ram_cea),
    .ram_adb(ram_adb), .ram_ceb(ram_ceb), .ram_dout(ram_dout),
    .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, read data valid one cycle after ram_ceb
  always @(posedge clk) begin
    if (ram_cea) ram_mem[ram_ada] <= ram_din;
    if (ram_ceb) ram_dout <= ram_mem[ram_adb];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor, sampling mid-cycle: logs handshakes, RAM addresses and hold stability
  initial begin : monitor
    logic       stall_prev;
    logic [8:0] held;
    stall_prev = 1'b0;
    held = 9'd0;
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) chk("hold", {rd_valid, rd_last, rd_data}, {1'b1, held});
        if (rd_valid && rd_ready) rx_q.push_back({rd_last, rd_data});
        if (ram_cea) wa_q.push_back(ram_ada);
        if (ram_ceb) ra_q.push_back(ram_adb);
        if (track_exp && wr_valid && wr_ready) begin
          exp_q.push_back({(wr_last || wpos == LL - 1), wr_data});
          wpos = (wr_last || wpos == LL - 1) ? 0 : wpos + 1;
        end
        stall_prev = rd_valid && !rd_ready;
        held = {rd_last, rd_data};
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; wr_data = 8'd0; rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    rx_q.delete(); exp_q.delete(); wa_q.delete(); ra_q.delete();
    wpos = 0;
    resetn = 1'b1;
  endtask

  // single-cycle offer, no handshake wait
  task automatic offer(input logic [7:0] d, input logic l);
    @(negedge clk);
    wr_valid = 1'b1; wr_data = d; wr_last = l;
  endtask

  task automatic wr_idle();
    @(negedge clk);
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  // hold the sample until wr_ready, bounded
  task automatic send_hs(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    wr_valid = 1'b1; wr_data = d; wr_last = l;
    #1;
    while (!wr_ready && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("send_ready", wr_ready, 1'b1);
  endtask

  task automatic wait_rx(input int n);
    int b;
    b = 0;
    while (rx_q.size() < n && b < 300) begin
      @(negedge clk);
      b++;
    end
    chk("rx_count", rx_q.size(), n);
  endtask

  initial begin
    logic [8:0] e;
    bit         found;
    bit         done_w;
    int         sent;

    // ---- reset values, with a sample offered during reset ----
    resetn = 1'b1; wr_valid = 1'b1; wr_data = 8'hAA; wr_last = 1'b1; rd_ready = 1'b1;
    #3 resetn = 1'b0;
    @(negedge clk); #1;
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_last", rd_last, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_cea", ram_cea, 1'b0);
    chk("rst_din", ram_din, 8'h00);
    chk("rst_ada", ram_ada, 11'h000);
    chk("rst_ceb", ram_ceb, 1'b0);
    chk("rst_adb", ram_adb, 11'h000);
    chk("rst_overrun", overrun_cnt, 8'h00);

    // ---- basic line 0x10..0x13 ----
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_hs(8'(8'h10 + i), 1'b0);
    wr_idle();
    wait_rx(4);
    for (int i = 0; i < 4; i++) begin
      e = {(i == 3), 8'(8'h10 + i)};
      chk("t1_rx", rx_q[i], e);
      chk("t1_waddr", wa_q[i], 11'(i));
    end
    repeat (3) @(negedge clk);
    // both banks must be free again: 8 samples with no reader all land
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) offer(8'(i), 1'b0);
    wr_idle();
    #1;
    chk("t1_all_accepted", wa_q.size(), 12);
    chk("t1_waddr_b1", wa_q[4], 11'h400);
    chk("t1_waddr_b0", wa_q[8], 11'h000);
    chk("t1_overrun", overrun_cnt, 8'h00);

    // ---- short line then full line ----
    do_reset();
    rd_ready = 1'b1;
    send_hs(8'h20, 1'b0); send_hs(8'h21, 1'b0); send_hs(8'h22, 1'b1);
    for (int i = 0; i < 4; i++) send_hs(8'(8'h30 + i), 1'b0);
    wr_idle();
    wait_rx(7);
    for (int i = 0; i < 7; i++) begin
      e = (i < 3) ? {(i == 2), 8'(8'h20 + i)} : {(i == 6), 8'(8'h30 + i - 3)};
      chk("t2_rx", rx_q[i], e);
      chk("t2_waddr", wa_q[i], (i < 3) ? 11'(i) : 11'(11'h400 + i - 3));
      chk("t2_raddr", ra_q[i], (i < 3) ? 11'(i) : 11'(11'h400 + i - 3));
    end

    // ---- both banks full, overrun, saturation, release ----
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) offer(8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      offer(8'hEE, 1'b0);
      #1;
      chk("t3_wr_ready_low", wr_ready, 1'b0);
      chk("t3_no_write", ram_cea, 1'b0);
    end
    wr_idle(); #1;
    chk("t3_overrun5", overrun_cnt, 8'd5);
    chk("t3_accepted", wa_q.size(), 8);
    for (int i = 0; i < 300; i++) offer(8'hEE, 1'b0);
    wr_idle(); #1;
    chk("t3_overrun_sat", overrun_cnt, 8'd255);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      rd_ready = 1'b1;
      #1;
      if (rd_valid && rd_last) begin
        found = 1'b1;
        chk("t3_wr_ready_before", wr_ready, 1'b0);
        @(negedge clk); #1;
        chk("t3_wr_ready_after", wr_ready, 1'b1);
      end
    end
    chk("t3_last_seen", found, 1'b1);
    wait_rx(8);
    for (int i = 0; i < 8; i++) begin
      e = {(i == 3 || i == 7), 8'(8'h40 + i)};
      chk("t3_rx", rx_q[i], e);
    end

    // ---- reset mid-line and mid-stream ----
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer(8'(8'h50 + i), 1'b0);
    offer(8'h60, 1'b0); offer(8'h61, 1'b0);
    wr_idle();
    repeat (3) @(negedge clk);
    #1;
    chk("t4_pre_valid", rd_valid, 1'b1);
    chk("t4_pre_data", rd_data, 8'h50);
    @(negedge clk);
    resetn = 1'b0; wr_valid = 1'b0;
    #1;
    chk("t4_rst_valid", rd_valid, 1'b0);
    chk("t4_rst_data", rd_data, 8'h00);
    chk("t4_rst_last", rd_last, 1'b0);
    chk("t4_rst_wr_ready", wr_ready, 1'b1);
    chk("t4_rst_ceb", ram_ceb, 1'b0);
    chk("t4_rst_adb", ram_adb, 11'h000);
    @(negedge clk);
    rx_q.delete(); wa_q.delete(); ra_q.delete();
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("t4_no_write", wa_q.size(), 0);
    chk("t4_no_read", ra_q.size(), 0);
    chk("t4_idle_valid", rd_valid, 1'b0);
    rd_ready = 1'b1;
    offer(8'h70, 1'b1);
    wr_idle();
    wait_rx(1);
    chk("t4_rx", rx_q[0], 9'h170);
    chk("t4_waddr", wa_q[0], 11'h000);
    repeat (10) @(negedge clk);
    chk("t4_no_stale", rx_q.size(), 1);

    // ---- random rd_ready over 40 lines with scoreboard ----
    do_reset();
    track_exp = 1'b1;
    done_w = 1'b0;
    sent = 0;
    fork
      begin
        for (int ln = 0; ln < 40; ln++) begin
          int len;
          len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LL - 1)) : LL;
          for (int i = 0; i < len; i++) begin
            send_hs(8'($urandom_range(0, 255)), (i == len - 1) && (len < LL));
            sent++;
          end
        end
        wr_idle();
        done_w = 1'b1;
      end
      begin
        int b;
        b = 0;
        while (b < 20000 && !(done_w && rx_q.size() == exp_q.size())) begin
          @(negedge clk);
          rd_ready = 1'($urandom_range(0, 1));
          b++;
        end
      end
    join
    @(negedge clk);
    rd_ready = 1'b1;
    track_exp = 1'b0;
    chk("t5_sent", exp_q.size(), sent);
    chk("t5_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) chk("t5_rx", rx_q[i], exp_q[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
